// File: rtl/keypad_pkg.sv
// keypad_pkg: scan states, key code width helper and active-low levels
// shared between the keypad scanner and the game FSM key decode.
package keypad_pkg;

  typedef logic [1:0] scan_state_t;

  localparam scan_state_t ST_SCAN = 2'd0;
  localparam scan_state_t ST_DEB  = 2'd1;
  localparam scan_state_t ST_HELD = 2'd2;
  localparam scan_state_t ST_REL  = 2'd3;

  localparam logic ACT_LO  = 1'b0;
  localparam logic IDLE_HI = 1'b1;

  function automatic int key_w(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_scan_fifo.sv
// key_fifo: small synchronous FIFO; a pop on a full FIFO frees the slot
// for a push in the same cycle.
module key_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr, rd;

  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign head  = mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      if (wr && !rd) cnt <= cnt + 1'b1;
      else if (rd && !wr) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: row-scanning matrix keypad front end with debounce,
// ghost rejection, optional auto-repeat and a small key FIFO.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 64,
  localparam int KW          = key_w(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] columna,
  output logic [ROWS-1:0] fila,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overflow
);

  localparam int DW  = $clog2(SCAN_DIV);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int RPW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam int RTW = $clog2(REPEAT_RATE + 1);

  logic [COLS-1:0] col_s1, col_s2;
  logic [DW-1:0]   div_q;
  scan_state_t     st_q;
  logic [RW-1:0]   row_q, row_nx;
  logic [CW-1:0]   col_q, low_idx;
  logic [7:0]      db_q, db_inc;
  logic [RPW-1:0]  rep_q;
  logic [RTW-1:0]  rate_q;
  logic            held_q, ovf_q;
  logic [COLS-1:0] low;
  logic            tick, one_low, same_key, all_high, db_done;
  logic            rep_at, rep_hit, rate_hit;
  logic            push, pop, full, empty;
  logic [KW-1:0]   code, head;

  assign tick = div_q == DW'(SCAN_DIV - 1);

  always_comb begin
    low     = '0;
    low_idx = '0;
    for (int i = 0; i < COLS; i++) begin
      low[i] = col_s2[i] == ACT_LO;
      if (low[i]) low_idx = CW'(i);
    end
  end

  // exactly one column low; two or more is treated as ghosting
  assign one_low  = (low != '0) && ((low & (low - 1'b1)) == '0);
  assign same_key = low == (COLS'(1) << col_q);
  assign all_high = low == '0;
  assign row_nx   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign db_inc   = (db_q == 8'hFF) ? db_q : db_q + 8'd1;
  assign db_done  = db_inc == 8'(DEBOUNCE);
  assign rep_at   = rep_q == RPW'(REPEAT_DELAY);
  assign rep_hit  = !rep_at && ((rep_q + 1'b1) == RPW'(REPEAT_DELAY));
  assign rate_hit = rate_q == RTW'(REPEAT_RATE - 1);
  assign code     = KW'(int'(row_q) * COLS + int'(col_q));

  always_comb begin
    push = 1'b0;
    if (tick && same_key) begin
      if (st_q == ST_DEB)
        push = db_done;
      else if (st_q == ST_HELD && REPEAT_DELAY != 0)
        push = rep_at ? rate_hit : rep_hit;
    end
  end

  assign pop = key_ready && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1 <= {COLS{IDLE_HI}};
      col_s2 <= {COLS{IDLE_HI}};
      div_q  <= '0;
      st_q   <= ST_SCAN;
      row_q  <= '0;
      col_q  <= '0;
      db_q   <= '0;
      rep_q  <= '0;
      rate_q <= '0;
      held_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      col_s1 <= columna;
      col_s2 <= col_s1;
      div_q  <= tick ? '0 : div_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
      if (tick) begin
        unique case (1'b1)
          st_q == ST_SCAN: begin
            if (one_low) begin
              col_q  <= low_idx;
              db_q   <= '0;
              rep_q  <= '0;
              rate_q <= '0;
              st_q   <= ST_DEB;
            end else begin
              row_q <= row_nx;
            end
          end
          st_q == ST_DEB: begin
            if (!same_key) begin
              st_q <= ST_SCAN;
            end else begin
              db_q <= db_inc;
              if (db_done) begin
                held_q <= 1'b1;
                st_q   <= ST_HELD;
              end
            end
          end
          st_q == ST_HELD: begin
            if (!same_key) begin
              db_q <= '0;
              st_q <= ST_REL;
            end else if (REPEAT_DELAY != 0) begin
              if (!rep_at) begin
                rep_q  <= rep_q + 1'b1;
                rate_q <= '0;
              end else begin
                rate_q <= rate_hit ? '0 : rate_q + 1'b1;
              end
            end
          end
          st_q == ST_REL: begin
            if (all_high) begin
              db_q <= db_inc;
              if (db_done) begin
                held_q <= 1'b0;
                row_q  <= row_nx;
                st_q   <= ST_SCAN;
              end
            end else if (same_key) begin
              st_q <= ST_HELD;
            end else begin
              db_q <= '0;
            end
          end
          default: st_q <= ST_SCAN;
        endcase
      end
    end
  end

  key_fifo #(
    .W     (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (code),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign fila      = ~(ROWS'(1) << row_q);
  assign key_valid = !empty;
  assign key_code  = empty ? '0 : head;
  assign key_held  = held_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad matrix model driving two scanners (no repeat,
// and 16/4 repeat) with a code scoreboard and tick-accurate timing checks.
module tb_keypad_scan;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int KW = 4;

  typedef struct {
    int r;
    int c;
    int c2;
    int hold;
    int code;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [C-1:0]   col_a, col_r;
  logic [R-1:0]   fila_a, fila_r;
  logic [KW-1:0]  code_a, code_r;
  logic           valid_a, valid_r, held_a, held_r, ovf_a, ovf_r;
  logic           ready_a = 1'b1;
  logic           ready_r = 1'b1;
  logic [R*C-1:0] kmap_a = '0;
  logic [R*C-1:0] kmap_r = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tk = 0;
  int mon_e;
  int exp_q[$];
  int rtk_q[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV (SD)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .columna   (col_a),
    .fila      (fila_a),
    .key_code  (code_a),
    .key_valid (valid_a),
    .key_ready (ready_a),
    .key_held  (held_a),
    .overflow  (ovf_a)
  );

  keypad_scan #(
    .SCAN_DIV     (SD),
    .REPEAT_DELAY (16),
    .REPEAT_RATE  (4)
  ) dut_r (
    .clk       (clk),
    .rst       (rst),
    .columna   (col_r),
    .fila      (fila_r),
    .key_code  (code_r),
    .key_valid (valid_r),
    .key_ready (ready_r),
    .key_held  (held_r),
    .overflow  (ovf_r)
  );

  // switch matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_a = '1;
    col_r = '1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        if (kmap_a[r*C+c] && !fila_a[r]) col_a[c] = 1'b0;
        if (kmap_r[r*C+c] && !fila_r[r]) col_r[c] = 1'b0;
      end
  end

  always @(posedge clk) begin
    if (rst) begin
      cyc <= 0;
    end else begin
      if (cyc % SD == SD - 1) tk <= tk + 1;
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_a && ready_a) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got code %0d required none", code_a);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(code_a) != mon_e) begin
          errors++;
          $display("FAIL pop_code: got %0d required %0d", code_a, mon_e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_r) begin
      rtk_q.push_back(tk);
      checks++;
      if (code_r != '0) begin
        errors++;
        $display("FAIL rep_code: got %0d required 0", code_r);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic next_tick();
    @(negedge clk);
    while (cyc % SD != SD - 1) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_row(input int sel, input int r, output int t);
    logic [R-1:0] want;
    logic [R-1:0] f;
    want = ~(R'(1) << r);
    t = -1;
    for (int n = 0; n < 4 * SD * (R + 2); n++) begin
      @(negedge clk);
      f = sel ? fila_r : fila_a;
      if (cyc % SD == SD - 1 && f == want) begin
        @(posedge clk);
        #1;
        t = tk;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL row_wait: row %0d never scanned, got none required one", r);
    end
  endtask

  task automatic press_key(input int r, input int c, input int hold,
                           input int code, input bit keep);
    int td;
    kmap_a = '0;
    kmap_a[r*C+c] = 1'b1;
    wait_row(0, r, td);
    if (keep) exp_q.push_back(code);
    repeat (DB - 1) next_tick();
    chk("held_early", held_a, 0);
    next_tick();
    chk("held_rise", held_a, 1);
    chk("valid_rise", valid_a, 1);
    repeat (hold - DB) next_tick();
    kmap_a = '0;
    repeat (DB) next_tick();
    chk("held_rel_early", held_a, 1);
    next_tick();
    chk("held_rel", held_a, 0);
  endtask

  task automatic ghost(input int r, input int c, input int c2, input int hold);
    logic [R-1:0] prev;
    int moves;
    moves = 0;
    kmap_a = '0;
    kmap_a[r*C+c]  = 1'b1;
    kmap_a[r*C+c2] = 1'b1;
    prev = fila_a;
    repeat (hold) begin
      next_tick();
      if (fila_a != prev) moves++;
      prev = fila_a;
    end
    chk("ghost_held", held_a, 0);
    chk("ghost_scan", moves, hold);
    kmap_a = '0;
    repeat (2) next_tick();
  endtask

  initial begin
    int td;
    int rexp[7];

    tbl[0] = '{r: 2, c: 1, c2: -1, hold: 20, code: 9};
    tbl[1] = '{r: 0, c: 0, c2: -1, hold: 10, code: 0};
    tbl[2] = '{r: 3, c: 3, c2: -1, hold: 12, code: 15};
    tbl[3] = '{r: 0, c: 1, c2: 3,  hold: 12, code: -1};
    tbl[4] = '{r: 1, c: 2, c2: -1, hold: 9,  code: 6};
    tbl[5] = '{r: 3, c: 0, c2: -1, hold: 10, code: 12};
    rexp = '{8, 24, 28, 32, 36, 40, 44};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_fila", fila_a, 14);
    chk("rst_valid", valid_a, 0);
    chk("rst_code", code_a, 0);
    chk("rst_held", held_a, 0);
    chk("rst_ovf", ovf_a, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].c2 < 0)
        press_key(tbl[i].r, tbl[i].c, tbl[i].hold, tbl[i].code, 1'b1);
      else
        ghost(tbl[i].r, tbl[i].c, tbl[i].c2, tbl[i].hold);
    end

    // bounce: low for 3 ticks, high for 1, then stable low
    kmap_a = '0;
    kmap_a[2*C+1] = 1'b1;
    wait_row(0, 2, td);
    repeat (2) next_tick();
    kmap_a = '0;
    next_tick();
    kmap_a[2*C+1] = 1'b1;
    next_tick();
    exp_q.push_back(9);
    repeat (DB - 1) next_tick();
    chk("bounce_early", held_a, 0);
    next_tick();
    chk("bounce_held", held_a, 1);
    kmap_a = '0;
    repeat (DB + 1) next_tick();
    chk("bounce_rel", held_a, 0);

    // auto-repeat: key 0 held for 40 ticks after debounce completes
    kmap_r = '0;
    kmap_r[0] = 1'b1;
    wait_row(1, 0, td);
    repeat (DB + 39) next_tick();
    kmap_r = '0;
    repeat (DB + 2) next_tick();
    chk("rep_count", rtk_q.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < rtk_q.size()) chk("rep_tick", rtk_q[i] - td, rexp[i]);
    chk("rep_held_rel", held_r, 0);

    // fill the FIFO with the consumer stalled
    ready_a = 1'b0;
    press_key(0, 2, DB, 2, 1'b1);
    press_key(1, 1, DB, 5, 1'b1);
    press_key(2, 3, DB, 11, 1'b1);
    press_key(3, 2, DB, 14, 1'b1);
    chk("full_ovf", ovf_a, 0);
    chk("full_valid", valid_a, 1);
    chk("full_head", code_a, 2);

    // push on full FIFO in the same cycle as a pop
    kmap_a = '0;
    kmap_a[1*C+0] = 1'b1;
    wait_row(0, 1, td);
    exp_q.push_back(4);
    repeat (DB - 1) next_tick();
    repeat (SD - 1) @(posedge clk);
    #1;
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    chk("simul_tick", tk - td, DB);
    chk("simul_ovf", ovf_a, 0);
    chk("simul_held", held_a, 1);
    chk("simul_head", code_a, 5);
    kmap_a = '0;
    repeat (DB + 1) next_tick();

    // push on full FIFO without a pop is dropped
    press_key(3, 1, DB, 13, 1'b0);
    chk("drop_ovf", ovf_a, 1);
    ready_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_valid", valid_a, 0);
    chk("drain_q", exp_q.size(), 0);

    // reset mid-debounce with a non-empty FIFO
    ready_a = 1'b0;
    press_key(0, 3, DB, 3, 1'b0);
    kmap_a = '0;
    kmap_a[2*C+2] = 1'b1;
    wait_row(0, 2, td);
    repeat (3) next_tick();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_valid", valid_a, 0);
    chk("mrst_fila", fila_a, 14);
    chk("mrst_held", held_a, 0);
    chk("mrst_ovf", ovf_a, 0);
    chk("mrst_code", code_a, 0);
    rst = 1'b0;
    ready_a = 1'b1;
    wait_row(0, 2, td);
    exp_q.push_back(10);
    repeat (DB - 1) next_tick();
    chk("redet_early", held_a, 0);
    next_tick();
    chk("redet_held", held_a, 1);
    kmap_a = '0;
    repeat (DB + 1) next_tick();
    chk("redet_rel", held_a, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("final_q", exp_q.size(), 0);
    chk("final_valid", valid_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
